// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the arbiter, the IF/MEM requesters and the external memory bus.
// slave = arbiter view; master = requester/memory view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_ack_o;
    logic [DATA_W-1:0] i_rdata_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [3:0]        d_sel_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;

    logic              flush_i;
    logic              stallreq_if_o;
    logic              stallreq_mem_o;

    logic              bus_req_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_ack_i;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              bus_err_o;

    modport slave (
        input  i_req_i, i_addr_i, d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
               flush_i, bus_ack_i, bus_rdata_i,
        output i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, stallreq_if_o, stallreq_mem_o,
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o
    );

    modport master (
        output i_req_i, i_addr_i, d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
               flush_i, bus_ack_i, bus_rdata_i,
        input  i_ack_o, i_rdata_o, d_ack_o, d_rdata_o, stallreq_if_o, stallreq_mem_o,
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the IF fetch port and the MEM data port; bus_req_o rises one edge
// after grant, requester ack one edge after bus_ack_i or timeout; requesters stall until acked.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave arb
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_cnt;
    logic              r_last_d;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [3:0]        r_bus_sel;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic              r_bus_err;
    logic              r_i_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_elig_i;
    logic w_elig_d;
    logic w_tmo;
    logic w_fin;
    logic w_grant_i;
    logic w_grant_d;
    logic w_end;
    logic w_done_i;
    logic w_done_d;

    // A side whose ack is showing this cycle has just been served and must not be re-granted.
    assign w_elig_i = arb.i_req_i & ~r_i_ack & ~arb.flush_i;
    assign w_elig_d = arb.d_req_i & ~r_d_ack;
    assign w_tmo    = (r_cnt == CNT_LAST) & ~arb.bus_ack_i;
    assign w_fin    = arb.bus_ack_i | w_tmo;

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_end        = 1'b0;
        w_done_i     = 1'b0;
        w_done_d     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig_d && (!w_elig_i || !r_last_d)) begin
                    w_grant_d    = 1'b1;
                    w_next_state = BUSY_D;
                end else if (w_elig_i) begin
                    w_grant_i    = 1'b1;
                    w_next_state = BUSY_I;
                end
            end
            BUSY_I: begin
                if (w_fin) begin
                    w_end        = 1'b1;
                    w_done_i     = ~arb.flush_i;
                    w_next_state = IDLE;
                end else if (arb.flush_i) begin
                    w_next_state = DRAIN;
                end
            end
            BUSY_D: begin
                if (w_fin) begin
                    w_end        = 1'b1;
                    w_done_d     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            DRAIN: begin
                if (w_fin) begin
                    w_end        = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= (w_next_state != r_state || r_state == IDLE) ? 8'd0 : r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d    <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'd0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_err   <= 1'b0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_i_ack   <= w_done_i;
            r_d_ack   <= w_done_d;
            r_bus_err <= w_end & w_tmo;
            if (w_grant_d) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= arb.d_we_i;
                r_bus_sel   <= arb.d_sel_i;
                r_bus_addr  <= arb.d_addr_i;
                r_bus_wdata <= arb.d_wdata_i;
                r_last_d    <= 1'b1;
            end else if (w_grant_i) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= 1'b0;
                r_bus_sel   <= 4'hF;
                r_bus_addr  <= arb.i_addr_i;
                r_bus_wdata <= '0;
                r_last_d    <= 1'b0;
            end else if (w_end) begin
                r_bus_req   <= 1'b0;
            end
            // A timed-out transfer delivers zero data rather than whatever is on the bus.
            if (w_done_i) r_i_rdata <= arb.bus_ack_i ? arb.bus_rdata_i : '0;
            if (w_done_d) r_d_rdata <= arb.bus_ack_i ? arb.bus_rdata_i : '0;
        end
    end

    assign arb.i_ack_o        = r_i_ack;
    assign arb.i_rdata_o      = r_i_rdata;
    assign arb.d_ack_o        = r_d_ack;
    assign arb.d_rdata_o      = r_d_rdata;
    assign arb.stallreq_if_o  = arb.i_req_i & ~r_i_ack;
    assign arb.stallreq_mem_o = arb.d_req_i & ~r_d_ack;
    assign arb.bus_req_o      = r_bus_req;
    assign arb.bus_we_o       = r_bus_we;
    assign arb.bus_sel_o      = r_bus_sel;
    assign arb.bus_addr_o     = r_bus_addr;
    assign arb.bus_wdata_o    = r_bus_wdata;
    assign arb.bus_err_o      = r_bus_err;
endmodule
